// File: rtl/tff_updown_counter.sv
// tff_updown_counter
//   Modulo-MODULUS up/down counter whose state is a bank of WIDTH T flip-flops.
//   Each cycle the next count is computed and the bank is fed the toggle
//   vector q ^ q_next, so a bit flips only when the count needs it to.
//   A raw active-low key is synchronised and falling-edge detected on-chip.
//
// Parameters
//   WIDTH     count register width
//   MODULUS   count range 0..MODULUS-1 (2 <= MODULUS <= 2**WIDTH)
//   SYNC_STEP 1: step_n is an async key (2-flop sync + falling-edge detect)
//             0: step_n is a synchronous active-low level, one event per clock
//
// Ports
//   clk     system clock, rising edge
//   rst     asynchronous active-high reset
//   en      count enable, gates step events only
//   step_n  active-low step strobe
//   up      direction, 1 = increment
//   load    synchronous parallel load (wins over stepping)
//   d       load value, clamped to MODULUS-1
//   q       current count
//   t_vec   toggle vector applied at the next edge
//   tc      terminal count for the current direction
//   wrap    one-cycle pulse after a wrapping step
//   ovf     sticky wrap flag, cleared by load or rst

// Single T flip-flop: holds unless t is high.
module tff_bit (
    input  logic clk,
    input  logic rst,
    input  logic t,
    output logic q
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst)    q <= 1'b0;
        else if (t) q <= ~q;
    end
endmodule

module tff_updown_counter #(
    parameter int WIDTH     = 8,
    parameter int MODULUS   = 200,
    parameter bit SYNC_STEP = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             step_n,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] t_vec,
    output logic             tc,
    output logic             wrap,
    output logic             ovf
);
    // MODULUS may equal 2**WIDTH, so the clamp compare needs one extra bit.
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULUS);
    localparam logic [WIDTH-1:0] Q_MAX   = WIDTH'(MODULUS - 1);

    if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_param_check
        $error("tff_updown_counter: MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH");
    end

    // ------------------------------------------------------------------
    // Step event generation
    // ------------------------------------------------------------------
    logic fire;

    if (SYNC_STEP) begin : g_key
        // History resets to "released" so a key that is up at reset release
        // cannot be mistaken for a press.
        logic s1, s2, p;
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                s1 <= 1'b1;
                s2 <= 1'b1;
                p  <= 1'b1;
            end else begin
                s1 <= step_n;
                s2 <= s1;
                p  <= s2;
            end
        end
        assign fire = p & ~s2;
    end else begin : g_level
        assign fire = ~step_n;
    end

    // ------------------------------------------------------------------
    // Next-state computation
    // ------------------------------------------------------------------
    logic             adv;
    logic             at_max;
    logic             at_zero;
    logic             wrap_next;
    logic [WIDTH-1:0] q_next;

    assign adv     = fire & en & ~load;
    assign at_max  = (q == Q_MAX);
    assign at_zero = (q == '0);
    assign tc      = up ? at_max : at_zero;

    always_comb begin
        q_next    = q;
        wrap_next = 1'b0;
        if (load) begin
            q_next = ({1'b0, d} < MOD_EXT) ? d : Q_MAX;
        end else if (adv && up) begin
            if (at_max) begin
                q_next    = '0;
                wrap_next = 1'b1;
            end else begin
                q_next = q + 1'b1;
            end
        end else if (adv) begin
            if (at_zero) begin
                q_next    = Q_MAX;
                wrap_next = 1'b1;
            end else begin
                q_next = q - 1'b1;
            end
        end
    end

    // Forced to zero under reset so the reported vector matches what the
    // bank will actually do (nothing) while rst is held.
    assign t_vec = rst ? '0 : (q ^ q_next);

    // ------------------------------------------------------------------
    // T flip-flop state bank
    // ------------------------------------------------------------------
    for (genvar i = 0; i < WIDTH; i++) begin : g_bank
        tff_bit u_bit (
            .clk (clk),
            .rst (rst),
            .t   (t_vec[i]),
            .q   (q[i])
        );
    end

    // ------------------------------------------------------------------
    // Wrap pulse and sticky overflow
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrap <= 1'b0;
            ovf  <= 1'b0;
        end else begin
            wrap <= wrap_next;          // wrap_next is already 0 under load
            if (load)           ovf <= 1'b0;
            else if (wrap_next) ovf <= 1'b1;
        end
    end
endmodule

// File: tb/tb_tff_updown_counter.sv
module tb_tff_updown_counter;
    localparam int W = 8;
    localparam int M = 200;

    logic         clk = 1'b0;
    logic         rst, en, step_n, up, load;
    logic [W-1:0] d, q, t_vec;
    logic         tc, wrap, ovf;

    always #5 clk = ~clk;

    tff_updown_counter #(.WIDTH(W), .MODULUS(M), .SYNC_STEP(1'b1)) dut (
        .clk(clk), .rst(rst), .en(en), .step_n(step_n), .up(up), .load(load),
        .d(d), .q(q), .t_vec(t_vec), .tc(tc), .wrap(wrap), .ovf(ovf)
    );

    typedef struct {
        logic [W-1:0] q;
        logic         wrap;
        logic         ovf;
    } exp_t;

    exp_t         sb[$];
    int           passed = 0;
    int           total  = 0;
    logic [W-1:0] m_q;
    logic         m_ovf;

    // Reference model of one step event
    function automatic logic [W-1:0] m_next(input logic [W-1:0] cur, input logic dir);
        if (dir) return (cur == W'(M-1)) ? '0 : cur + 1'b1;
        else     return (cur == '0) ? W'(M-1) : cur - 1'b1;
    endfunction

    function automatic logic m_wraps(input logic [W-1:0] cur, input logic dir);
        return dir ? (cur == W'(M-1)) : (cur == '0);
    endfunction

    // Push the expected outcome of a step event (or a blocked one) and advance the model.
    task automatic push_step(input logic counts);
        exp_t e;
        if (counts) begin
            e.wrap = m_wraps(m_q, up);
            e.q    = m_next(m_q, up);
            e.ovf  = m_ovf | e.wrap;
        end else begin
            e.wrap = 1'b0;
            e.q    = m_q;
            e.ovf  = m_ovf;
        end
        m_q   = e.q;
        m_ovf = e.ovf;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full key press: captures t_vec in the fire cycle and outputs just after the update edge.
    task automatic press(output logic [W-1:0] tv, output logic [W-1:0] qo,
                         output logic wo, output logic oo);
        step_n = 1'b0;
        tick(); tick();
        tv = t_vec;
        tick();
        qo = q; wo = wrap; oo = ovf;
        step_n = 1'b1;
        tick(); tick(); tick();
    endtask

    task automatic do_load(input logic [W-1:0] val);
        load = 1'b1; d = val;
        tick();
        load = 1'b0;
    endtask

    task automatic test_reset();
        exp_t e;
        rst = 1'b1; en = 1'b1; step_n = 1'b1; up = 1'b1; load = 1'b0; d = '0;
        tick(); tick();
        load = 1'b1; d = 8'd5;
        #1;
        total++; if (q !== 8'd0 || wrap !== 1'b0 || ovf !== 1'b0)
            $display("FAIL reset_state: q=%0d wrap=%b ovf=%b want 0/0/0", q, wrap, ovf); else passed++;
        total++; if (t_vec !== 8'h00)
            $display("FAIL reset_tvec: got %h want 00", t_vec); else passed++;
        tick();
        load = 1'b0; d = '0;
        rst = 1'b0;
        m_q = '0; m_ovf = 1'b0;
        tick(); tick();
        e.q = '0; e.wrap = 1'b0; e.ovf = 1'b0;
        sb.push_back(e);
        e = sb.pop_front();
        total++; if (q !== e.q || wrap !== e.wrap)
            $display("FAIL reset_release_idle: q=%0d wrap=%b want %0d/%b", q, wrap, e.q, e.wrap); else passed++;
    endtask

    task automatic test_sync_latency();
        exp_t e;
        step_n = 1'b0;
        tick();
        total++; if (q !== 8'd0 || t_vec !== 8'h00)
            $display("FAIL sync_edge1: q=%0d tvec=%h want 0/00", q, t_vec); else passed++;
        push_step(1'b1);
        tick();
        total++; if (q !== 8'd0 || t_vec !== 8'h01)
            $display("FAIL sync_edge2: q=%0d tvec=%h want 0/01", q, t_vec); else passed++;
        tick();
        e = sb.pop_front();
        total++; if (q !== e.q || wrap !== e.wrap || ovf !== e.ovf)
            $display("FAIL sync_edge3: q=%0d wrap=%b ovf=%b want %0d/%b/%b", q, wrap, ovf, e.q, e.wrap, e.ovf); else passed++;
        tick(); tick();
        total++; if (q !== 8'd1 || t_vec !== 8'h00)
            $display("FAIL sync_hold: q=%0d tvec=%h want 1/00", q, t_vec); else passed++;
        step_n = 1'b1;
        tick(); tick(); tick();
        total++; if (q !== 8'd1)
            $display("FAIL sync_release: q=%0d want 1", q); else passed++;
    endtask

    task automatic test_up_wrap();
        exp_t e; logic [W-1:0] tv, qo; logic wo, oo;
        up = 1'b1;
        do_load(8'd198); m_q = 8'd198; m_ovf = 1'b0;
        total++; if (q !== 8'd198 || ovf !== 1'b0)
            $display("FAIL upwrap_load: q=%0d ovf=%b want 198/0", q, ovf); else passed++;
        push_step(1'b1);
        press(tv, qo, wo, oo);
        e = sb.pop_front();
        total++; if (qo !== e.q || wo !== e.wrap || oo !== e.ovf || tc !== 1'b1)
            $display("FAIL upwrap_199: q=%0d wrap=%b ovf=%b tc=%b want %0d/%b/%b/1", qo, wo, oo, tc, e.q, e.wrap, e.ovf); else passed++;
        push_step(1'b1);
        press(tv, qo, wo, oo);
        e = sb.pop_front();
        total++; if (qo !== e.q || wo !== e.wrap || oo !== e.ovf)
            $display("FAIL upwrap_0: q=%0d wrap=%b ovf=%b want %0d/%b/%b", qo, wo, oo, e.q, e.wrap, e.ovf); else passed++;
        total++; if (tv !== 8'hC7)
            $display("FAIL upwrap_tvec: got %h want c7", tv); else passed++;
        total++; if (wrap !== 1'b0 || ovf !== 1'b1)
            $display("FAIL upwrap_after: wrap=%b ovf=%b want 0/1", wrap, ovf); else passed++;
    endtask

    task automatic test_down_wrap();
        exp_t e; logic [W-1:0] tv, qo; logic wo, oo;
        do_load(8'd1); m_q = 8'd1; m_ovf = 1'b0;
        up = 1'b0;
        push_step(1'b1);
        press(tv, qo, wo, oo);
        e = sb.pop_front();
        total++; if (qo !== e.q || wo !== e.wrap || oo !== e.ovf || tc !== 1'b1)
            $display("FAIL down_to0: q=%0d wrap=%b ovf=%b tc=%b want %0d/%b/%b/1", qo, wo, oo, tc, e.q, e.wrap, e.ovf); else passed++;
        push_step(1'b1);
        press(tv, qo, wo, oo);
        e = sb.pop_front();
        total++; if (qo !== e.q || wo !== e.wrap || oo !== e.ovf || tv !== 8'hC7)
            $display("FAIL down_wrap: q=%0d wrap=%b ovf=%b tv=%h want %0d/%b/%b/c7", qo, wo, oo, tv, e.q, e.wrap, e.ovf); else passed++;
        total++; if (tc !== 1'b0)
            $display("FAIL tc_down_at199: got %b want 0", tc); else passed++;
        up = 1'b1;
        #1;
        total++; if (tc !== 1'b1)
            $display("FAIL tc_dir_change: got %b want 1", tc); else passed++;
        push_step(1'b1);
        press(tv, qo, wo, oo);
        e = sb.pop_front();
        total++; if (qo !== e.q || wo !== e.wrap || oo !== e.ovf)
            $display("FAIL dirchg_step: q=%0d wrap=%b ovf=%b want %0d/%b/%b", qo, wo, oo, e.q, e.wrap, e.ovf); else passed++;
    endtask

    task automatic test_load_priority();
        exp_t e;
        up = 1'b1;
        step_n = 1'b0;
        tick(); tick();
        // fire is active in this cycle; load must override it
        load = 1'b1; d = 8'd250;
        #1;
        total++; if (t_vec !== (q ^ 8'd199))
            $display("FAIL load_tvec: got %h want %h", t_vec, q ^ 8'd199); else passed++;
        m_q = 8'd199; m_ovf = 1'b0;
        e.q = m_q; e.wrap = 1'b0; e.ovf = 1'b0;
        sb.push_back(e);
        tick();
        load = 1'b0;
        e = sb.pop_front();
        total++; if (q !== e.q || wrap !== e.wrap || ovf !== e.ovf)
            $display("FAIL load_clamp: q=%0d wrap=%b ovf=%b want %0d/%b/%b", q, wrap, ovf, e.q, e.wrap, e.ovf); else passed++;
        step_n = 1'b1;
        tick(); tick(); tick();
        total++; if (q !== 8'd199)
            $display("FAIL load_no_late_count: q=%0d want 199", q); else passed++;
        do_load(8'd5); m_q = 8'd5;
        total++; if (q !== 8'd5)
            $display("FAIL load_5: q=%0d want 5", q); else passed++;
    endtask

    task automatic test_enable();
        exp_t e; logic [W-1:0] tv, qo; logic wo, oo;
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            push_step(1'b0);
            press(tv, qo, wo, oo);
            e = sb.pop_front();
            total++; if (qo !== e.q || tv !== 8'h00 || wo !== 1'b0)
                $display("FAIL en_gate%0d: q=%0d tv=%h wrap=%b want %0d/00/0", i, qo, tv, wo, e.q); else passed++;
        end
        en = 1'b1;
        push_step(1'b1);
        press(tv, qo, wo, oo);
        e = sb.pop_front();
        total++; if (qo !== e.q || oo !== e.ovf)
            $display("FAIL en_step: q=%0d ovf=%b want %0d/%b", qo, oo, e.q, e.ovf); else passed++;
    endtask

    task automatic test_async_reset();
        do_load(8'd137);
        total++; if (q !== 8'd137)
            $display("FAIL ar_setup137: q=%0d want 137", q); else passed++;
        #2 rst = 1'b1;
        #1;
        total++; if (q !== 8'd0 || wrap !== 1'b0 || ovf !== 1'b0)
            $display("FAIL ar_mid137: q=%0d wrap=%b ovf=%b want 0/0/0", q, wrap, ovf); else passed++;
        tick();
        rst = 1'b0;
        up = 1'b1;
        do_load(8'd199);
        step_n = 1'b0;
        tick(); tick(); tick();
        total++; if (q !== 8'd0 || wrap !== 1'b1 || ovf !== 1'b1)
            $display("FAIL ar_setup_wrap: q=%0d wrap=%b ovf=%b want 0/1/1", q, wrap, ovf); else passed++;
        #2 rst = 1'b1;
        #1;
        total++; if (wrap !== 1'b0 || ovf !== 1'b0 || t_vec !== 8'h00)
            $display("FAIL ar_midwrap: wrap=%b ovf=%b tvec=%h want 0/0/00", wrap, ovf, t_vec); else passed++;
        step_n = 1'b1;
        tick(); tick();
        rst = 1'b0;
        tick(); tick(); tick(); tick();
        total++; if (q !== 8'd0 || wrap !== 1'b0 || ovf !== 1'b0)
            $display("FAIL ar_no_spurious: q=%0d wrap=%b ovf=%b want 0/0/0", q, wrap, ovf); else passed++;
    endtask

    initial begin
        test_reset();
        test_sync_latency();
        test_up_wrap();
        test_down_wrap();
        test_load_priority();
        test_enable();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
